tsl235r_freq_counter: RTL and testbench
=======================================

TSL235R_FREQ_COUNTER -- requirements
Module: tsl235r_freq_counter

Interface
REQ-001 Parameter COUNT_W, default 32, SHALL set the width of the edge counter and of count_out.
REQ-002 Parameter GATE_W, default 32, SHALL set the width of gate_cycles and the gate timer.
REQ-003 Port ACLK  input  1  SHALL be the single clock; all logic is on its rising edge.
REQ-004 Port ARESET  input  1  SHALL be the synchronous, active-high reset.
REQ-005 Port freq_in  input  1  SHALL carry the asynchronous TSL235R square-wave output.
REQ-006 Port enable  input  1  SHALL be the run control from the AXI register stage.
REQ-007 Port single_shot  input  1  SHALL select the mode: 1 = one window then idle; 0 = continuous back-to-back windows.
REQ-008 Port start  input  1  SHALL be a one-cycle pulse that starts a window.
REQ-009 Port gate_cycles  input  GATE_W  SHALL give the window length in ACLK cycles.
REQ-010 Port count_out  output  COUNT_W  SHALL hold the last completed window's rising-edge count.
REQ-011 Port count_valid  output  1  SHALL indicate that count_out is new and not yet consumed.
REQ-012 Port count_ack  input  1  SHALL be the consumer acknowledge from the register stage.
REQ-013 Port busy  output  1  SHALL be high while a window is open.
REQ-014 Port saturated  output  1  SHALL be high when the current count_out was clipped.
REQ-015 Port overrun  output  1  SHALL be a sticky flag: a result was replaced before it was acknowledged.

Function
REQ-016 freq_in SHALL pass a 2-flop synchronizer; a rising edge is detected one cycle later (3-cycle input latency).
REQ-017 FSM SHALL have states IDLE and COUNT only.
REQ-018 IDLE->COUNT SHALL occur when enable=1 and either start=1 or single_shot=0.
- On entry, the gate timer loads max(gate_cycles,1).
- gate_cycles is sampled only at window start.
REQ-019 In COUNT, each cycle SHALL decrement the timer and add the detected edge to the counter; the window lasts exactly the loaded number of cycles.
REQ-020 On the terminal cycle (timer==1), the terminal-cycle edge SHALL be included.
- count_out updates on the next edge, count_valid is set, and the counter clears.
REQ-021 After the terminal cycle, the FSM SHALL reload and stay in COUNT if single_shot=0 and enable=1; otherwise it goes to IDLE.
- No dead cycles in continuous mode.
REQ-022 The counter SHALL saturate at all-ones; saturated SHALL be set with the corresponding count_out.
REQ-023 enable=0 during COUNT SHALL abort the window next cycle: go to IDLE, discard the partial count, leave count_out and count_valid unchanged.
REQ-024 count_valid SHALL clear on the cycle after count_ack=1.
- If a new result lands on the same cycle as count_ack, the new result wins and count_valid stays 1 without setting overrun.
REQ-025 A new result while count_valid=1 and count_ack=0 SHALL overwrite count_out and set overrun.
- overrun clears only on reset or when count_ack=1 and enable=0.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 busy SHALL equal (state==COUNT).

Reset
REQ-028 ARESET=1 SHALL, at the next ACLK edge, force:
- state IDLE;
- count_out=0;
- count_valid, busy, saturated, overrun = 0;
- timer, counter and synchronizer flops = 0.
REQ-029 Reset mid-window SHALL discard the window with no count_valid pulse.

Structure
REQ-030 Shared package tsl235r_pkg SHALL hold the FSM state typedef and the default COUNT_W/GATE_W constants.
REQ-031 Sub-module tsl235r_sync_edge SHALL implement the synchronizer plus rising-edge detect, outputting a one-cycle edge strobe.

Verification
REQ-032 gate_cycles=100, freq_in period 10 cycles, continuous mode -> every window reports count_out=10 (+/-1 for the first window), count_valid each 100 cycles.
REQ-033 gate_cycles=0, single_shot, start pulse -> window of 1 cycle, busy high 1 cycle, exactly one count_valid.
REQ-034 COUNT_W=8, gate_cycles=1000, freq_in period 2 -> count_out=255, saturated=1.
REQ-035 gate_cycles=50, count_ack held 0 across two windows -> overrun=1, count_out equals the second window's value; count_ack=1 -> count_valid=0 next cycle.
REQ-036 enable dropped at cycle 20 of a 100-cycle window -> busy=0 next cycle, no count_valid, prior count_out retained.
REQ-037 ARESET pulsed at cycle 30 of a window -> all outputs 0 next cycle; a restart then yields a correct count.

Source files
------------

// File: rtl/tsl235r_pkg.sv
// Shared definitions for the TSL235R light-to-frequency counter.
//   state_e      : FSM state encoding (IDLE / COUNT)
//   DEF_COUNT_W  : default width of the edge counter and count_out
//   DEF_GATE_W   : default width of gate_cycles and the gate timer
package tsl235r_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  localparam int unsigned DEF_COUNT_W = 32;
  localparam int unsigned DEF_GATE_W  = 32;

endpackage

// File: rtl/tsl235r_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector for the asynchronous
// TSL235R square wave.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset, clears all three flops
//   din_i  : asynchronous input
//   edge_o : one-cycle strobe, high while a synchronized rising edge is seen
// An input rise is counted by the consumer on the third clock edge after it.
module tsl235r_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic din_i,
  output logic edge_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= din_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign edge_o = sync_q & ~prev_q;

endmodule

// File: rtl/tsl235r_freq_counter.sv
// Gated rising-edge counter for a TSL235R light-to-frequency sensor.
//   ACLK / ARESET : clock and synchronous active-high reset
//   freq_in       : asynchronous sensor square wave
//   enable        : run control; dropping it aborts an open window
//   single_shot   : 1 = one window per start pulse, 0 = back-to-back windows
//   start         : one-cycle pulse opening a window (ignored while busy)
//   gate_cycles   : window length in ACLK cycles (0 treated as 1)
//   count_out     : rising-edge count of the last completed window
//   count_valid   : count_out is new and not yet acknowledged
//   count_ack     : consumer acknowledge
//   busy          : a window is open
//   saturated     : count_out was clipped at all-ones
//   overrun       : sticky, an unacknowledged result was overwritten
module tsl235r_freq_counter
  import tsl235r_pkg::*;
#(
  parameter int unsigned COUNT_W = DEF_COUNT_W,
  parameter int unsigned GATE_W  = DEF_GATE_W
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic               freq_in,
  input  logic               enable,
  input  logic               single_shot,
  input  logic               start,
  input  logic [GATE_W-1:0]  gate_cycles,
  output logic [COUNT_W-1:0] count_out,
  output logic               count_valid,
  input  logic               count_ack,
  output logic               busy,
  output logic               saturated,
  output logic               overrun
);

  state_e               state_q, state_d;
  logic [GATE_W-1:0]    timer_q, timer_d;
  logic [COUNT_W-1:0]   cnt_q, cnt_d;
  logic                 clip_q, clip_d;
  logic [COUNT_W-1:0]   count_out_q, count_out_d;
  logic                 valid_q, valid_d;
  logic                 sat_q, sat_d;
  logic                 ovr_q, ovr_d;

  logic                 edge_stb;
  logic                 result;
  logic                 cnt_at_max;
  logic [COUNT_W-1:0]   cnt_inc;
  logic                 clip_inc;
  logic [GATE_W-1:0]    gate_load;

  tsl235r_sync_edge u_sync_edge (
    .clk_i  (ACLK),
    .rst_i  (ARESET),
    .din_i  (freq_in),
    .edge_o (edge_stb)
  );

  // A zero gate still yields a one-cycle window.
  assign gate_load  = (gate_cycles == '0) ? GATE_W'(1) : gate_cycles;
  assign cnt_at_max = &cnt_q;
  // Saturating increment; clip remembers that an edge was lost this window.
  assign cnt_inc    = (edge_stb && !cnt_at_max) ? cnt_q + COUNT_W'(1) : cnt_q;
  assign clip_inc   = clip_q | (edge_stb & cnt_at_max);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      cnt_q       <= '0;
      clip_q      <= 1'b0;
      count_out_q <= '0;
      valid_q     <= 1'b0;
      sat_q       <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cnt_q       <= cnt_d;
      clip_q      <= clip_d;
      count_out_q <= count_out_d;
      valid_q     <= valid_d;
      sat_q       <= sat_d;
      ovr_q       <= ovr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    cnt_d       = cnt_q;
    clip_d      = clip_q;
    count_out_d = count_out_q;
    valid_d     = valid_q;
    sat_d       = sat_q;
    ovr_d       = ovr_q;
    result      = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable && (start || !single_shot)) begin
          state_d = COUNT;
          timer_d = gate_load;
          cnt_d   = '0;
          clip_d  = 1'b0;
        end
      end
      COUNT: begin
        if (!enable) begin
          // Abort: the partial count is thrown away, published result kept.
          state_d = IDLE;
          timer_d = '0;
          cnt_d   = '0;
          clip_d  = 1'b0;
        end else if (timer_q == GATE_W'(1)) begin
          // Terminal cycle: its own edge is part of the published count.
          result      = 1'b1;
          count_out_d = cnt_inc;
          sat_d       = clip_inc;
          cnt_d       = '0;
          clip_d      = 1'b0;
          if (!single_shot) begin
            timer_d = gate_load;
          end else begin
            state_d = IDLE;
            timer_d = '0;
          end
        end else begin
          timer_d = timer_q - GATE_W'(1);
          cnt_d   = cnt_inc;
          clip_d  = clip_inc;
        end
      end
      default: state_d = IDLE;
    endcase

    // A result landing together with an ack replaces the acked one cleanly.
    if (result) begin
      valid_d = 1'b1;
      if (valid_q && !count_ack) begin
        ovr_d = 1'b1;
      end
    end else if (count_ack) begin
      valid_d = 1'b0;
    end

    // Overrun is cleared only by an ack while the counter is stopped.
    if (count_ack && !enable) begin
      ovr_d = 1'b0;
    end
  end

  assign count_out   = count_out_q;
  assign count_valid = valid_q;
  assign busy        = (state_q == COUNT);
  assign saturated   = sat_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_tsl235r_freq_counter.sv
// Self-checking bench for tsl235r_freq_counter (COUNT_W=8, GATE_W=16).
module tb_tsl235r_freq_counter;

  localparam int CW   = 8;
  localparam int GW   = 16;
  localparam int NCYC = 40000;
  localparam int CMAX = 255;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          freq_in;
  logic          enable;
  logic          single_shot;
  logic          start;
  logic [GW-1:0] gate_cycles;
  logic [CW-1:0] count_out;
  logic          count_valid;
  logic          count_ack;
  logic          busy;
  logic          saturated;
  logic          overrun;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // edge_at[c] = 1 when a sensor rise must be counted by clock edge c.
  bit   edge_at [NCYC];
  int   fp        = 0;    // <0 random, 0 held low, >0 period in cycles
  int   phase     = 0;
  logic lvl_prev  = 1'b0;

  always #5 ACLK = ~ACLK;

  tsl235r_freq_counter #(.COUNT_W(CW), .GATE_W(GW)) dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .freq_in     (freq_in),
    .enable      (enable),
    .single_shot (single_shot),
    .start       (start),
    .gate_cycles (gate_cycles),
    .count_out   (count_out),
    .count_valid (count_valid),
    .count_ack   (count_ack),
    .busy        (busy),
    .saturated   (saturated),
    .overrun     (overrun)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one clock edge, then drive the sensor a little after the edge.
  task automatic tick();
    logic lvl;
    @(posedge ACLK);
    cyc++;
    #1;
    if (cyc >= NCYC - 8) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", cyc, NCYC - 8);
      $fatal(1, "cycle budget exhausted");
    end
    if (fp < 0)       lvl = 1'($urandom_range(0, 1));
    else if (fp == 0) lvl = 1'b0;
    else begin
      lvl = ((phase % fp) < (fp / 2));
      phase++;
    end
    // Sampled at edge cyc+1, synchronized at cyc+2, counted at cyc+3.
    if (lvl && !lvl_prev) edge_at[cyc + 3] = 1'b1;
    lvl_prev = lvl;
    freq_in  = lvl;
  endtask

  function automatic int model_edges(input int a, input int b);
    int s = 0;
    for (int i = a; i <= b; i++) s += int'(edge_at[i]);
    return s;
  endfunction

  function automatic int gmax1(input int g);
    return (g == 0) ? 1 : g;
  endfunction

  typedef struct {
    int gate;
    int period;
    int exp_len;
    int exp_count;
    bit exp_sat;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int   t0, n, busy_n, win_l, win_n, g_cur, k, guard, exp_e;
    logic ack_drv, m_valid, m_ovr, seen;

    vecs[0] = '{100,  10, 100,  10, 1'b0};
    vecs[1] = '{50,    5,  50,  10, 1'b0};
    vecs[2] = '{64,    4,  64,  16, 1'b0};
    vecs[3] = '{2,     2,   2,   1, 1'b0};
    vecs[4] = '{0,     0,   1,   0, 1'b0};
    vecs[5] = '{510,   2, 510, 255, 1'b0};
    vecs[6] = '{1000,  2, 1000, 255, 1'b1};

    ARESET = 1'b1; freq_in = 1'b0; enable = 1'b0; single_shot = 1'b1;
    start = 1'b0; count_ack = 1'b0; gate_cycles = '0;
    tick(); tick();
    check("rst_count_out", count_out, 0);
    check("rst_valid", count_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_saturated", saturated, 0);
    check("rst_overrun", overrun, 0);
    ARESET = 1'b0;

    // Single-shot windows from the vector table.
    for (int v = 0; v < 7; v++) begin
      fp = vecs[v].period; phase = 0;
      gate_cycles = GW'(vecs[v].gate); single_shot = 1'b1; enable = 1'b1;
      repeat (20) tick();
      start = 1'b1;
      tick(); t0 = cyc; start = 1'b0;
      gate_cycles = GW'($urandom);          // must not affect the open window
      busy_n = int'(busy); n = 0;
      while (!count_valid && n < vecs[v].gate + 20) begin
        tick(); n++;
        if (busy) busy_n++;
        start = (n == 1) && !count_valid;   // ignored while busy
      end
      start = 1'b0;
      check("vec_valid", count_valid, 1);
      check("vec_latency", cyc - t0, vecs[v].exp_len);
      check("vec_count", count_out, vecs[v].exp_count);
      check("vec_saturated", saturated, vecs[v].exp_sat);
      check("vec_busy_cycles", busy_n, vecs[v].exp_len);
      check("vec_idle_after", busy, 0);
      count_ack = 1'b1; tick(); count_ack = 1'b0;
      check("vec_ack_clears", count_valid, 0);
      $display("vector %0d: gate=%0d period=%0d count=%0d sat=%0d", v, vecs[v].gate,
               vecs[v].period, count_out, saturated);
    end

    // Continuous mode, random sensor, random gates and acks.
    fp = -1;
    repeat (5) tick();
    g_cur = $urandom_range(0, 40); gate_cycles = GW'(g_cur);
    single_shot = 1'b0; enable = 1'b1;
    tick(); win_l = cyc; win_n = gmax1(g_cur);
    g_cur = $urandom_range(0, 40); gate_cycles = GW'(g_cur);
    m_valid = 1'b0; m_ovr = 1'b0; k = 0; guard = 0;
    while (k < 12 && guard < 3000) begin
      ack_drv = ($urandom_range(0, 3) == 0);
      count_ack = ack_drv;
      start = 1'($urandom_range(0, 1));
      tick(); guard++;
      if (cyc == win_l + win_n) begin
        if (m_valid && !ack_drv) m_ovr = 1'b1;
        m_valid = 1'b1;
        exp_e = model_edges(win_l + 1, win_l + win_n);
        check("rnd_count", count_out, (exp_e > CMAX) ? CMAX : exp_e);
        check("rnd_saturated", saturated, exp_e > CMAX);
        check("rnd_busy", busy, 1);
        $display("window %0d: len=%0d count=%0d expected=%0d", k, win_n, count_out, exp_e);
        win_l = cyc; win_n = gmax1(g_cur);
        g_cur = $urandom_range(0, 40); gate_cycles = GW'(g_cur);
        k++;
      end else if (ack_drv) begin
        m_valid = 1'b0;
      end
      check("rnd_valid", count_valid, m_valid);
      check("rnd_overrun", overrun, m_ovr);
    end
    check("rnd_windows_done", k, 12);
    count_ack = 1'b0; start = 1'b0; enable = 1'b0;
    tick();
    check("rnd_abort_busy", busy, 0);
    count_ack = 1'b1; tick(); count_ack = 1'b0;
    check("rnd_clear_valid", count_valid, 0);
    check("rnd_clear_overrun", overrun, 0);

    // Two unacknowledged windows of 50 cycles -> overrun.
    fp = 5; phase = 0; gate_cycles = GW'(50); single_shot = 1'b0;
    repeat (20) tick();
    enable = 1'b1;
    tick(); win_l = cyc;
    repeat (50) tick();
    check("ovr_first_valid", count_valid, 1);
    check("ovr_first_flag", overrun, 0);
    repeat (50) tick();
    check("ovr_second_valid", count_valid, 1);
    check("ovr_second_flag", overrun, 1);
    check("ovr_second_count", count_out, 10);
    $display("overrun seq: count=%0d overrun=%0d", count_out, overrun);
    count_ack = 1'b1; tick();
    check("ovr_ack_valid", count_valid, 0);
    check("ovr_ack_keeps_flag", overrun, 1);
    enable = 1'b0; tick(); count_ack = 1'b0;
    check("ovr_stop_busy", busy, 0);
    check("ovr_stop_clear", overrun, 0);

    // Abort at cycle 20 of a 100-cycle window.
    fp = 10; gate_cycles = GW'(100); single_shot = 1'b1; enable = 1'b1; start = 1'b1;
    tick(); t0 = cyc; start = 1'b0;
    repeat (20) tick();
    enable = 1'b0;
    tick();
    check("abort_busy", busy, 0);
    seen = 1'b0;
    repeat (120) begin
      tick();
      if (count_valid) seen = 1'b1;
    end
    check("abort_no_valid", seen, 0);
    check("abort_count_kept", count_out, 10);
    $display("abort seq: busy=%0d count=%0d", busy, count_out);

    // Reset at cycle 30 of a window, then a clean restart.
    enable = 1'b1; start = 1'b1;
    tick(); t0 = cyc; start = 1'b0;
    repeat (25) tick();
    fp = 0;
    repeat (5) tick();
    ARESET = 1'b1;
    tick();
    check("mid_rst_count_out", count_out, 0);
    check("mid_rst_valid", count_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_saturated", saturated, 0);
    check("mid_rst_overrun", overrun, 0);
    ARESET = 1'b0;
    fp = 10; phase = 0;
    repeat (20) tick();
    start = 1'b1;
    tick(); t0 = cyc; start = 1'b0;
    n = 0;
    while (!count_valid && n < 130) begin
      tick(); n++;
    end
    check("restart_latency", cyc - t0, 100);
    check("restart_count", count_out, 10);
    $display("restart seq: count=%0d", count_out);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
